shift_arbiter_ctrl: RTL and testbench
=====================================

SHIFT_ARBITER_CTRL -- requirements
Module: shift_arbiter_ctrl

Interface
REQ-001 Parameter RR_INIT, default 1'b1: initial last-grant value; 1 means requester 0 wins the first contention after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has a shift operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation from requester N is accepted this cycle.
REQ-006 req0_op / req1_op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 reserved (executed as SLL).
REQ-007 req0_data / req1_data  input  32  operand to shift.
REQ-008 req0_shamt / req1_shamt  input  5  shift amount, 0-31.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_data  output  32  shift result.
REQ-012 resp_id  output  1  index of the requester that owns resp_data.
REQ-013 sh_idata  output  32  operand to the shared 32-bit left barrel shifter.
REQ-014 sh_shift_len  output  5  shift amount to the shared shifter.
REQ-015 sh_odata  input  32  combinational result from the shared shifter.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, SHIFT, RESP; IDLE->SHIFT on an accept; SHIFT->RESP unconditionally; RESP->IDLE on resp_valid&&resp_ready; RESP otherwise holds.
REQ-018 reqN_ready is combinational: high only in IDLE for the granted requester; at most one ready high per cycle; ready never depends on resp_ready.
REQ-019 Grant in IDLE: sole valid requester wins; both valid -> requester != last_grant wins; last_grant updates to the winner on accept.
REQ-020 On accept: op, data, shamt and id register into internal operand registers; reserved op 10 stored as SLL.
REQ-021 sh_idata driven from operand registers in all states: data for SLL, bit-reversed data for SRL/SRA; sh_shift_len = registered shamt.
REQ-022 In SHIFT, result register captures: SLL -> sh_odata; SRL -> bit-reverse(sh_odata); SRA -> bit-reverse(sh_odata) OR top-shamt-bits mask when data[31]=1.
REQ-023 Latency: accept at edge N -> resp_valid high after edge N+2; minimum issue interval 3 cycles.
REQ-024 resp_valid high only in RESP; resp_data and resp_id stable throughout RESP until handshake.
REQ-025 shamt=0 returns data unchanged for all ops, including SRA.
REQ-026 A requester dropping valid before acceptance is not served; no requester state is retained.
REQ-027 No accept in SHIFT or RESP even if valid asserted; requests wait in IDLE.

Reset
REQ-028 rst_n low forces immediately: state IDLE, resp_valid 0, busy 0, req0_ready/req1_ready follow IDLE grant logic, resp_data 0, resp_id 0, operand registers 0 (sh_idata 0, sh_shift_len 0), last_grant = RR_INIT.
REQ-029 Reset mid-operation discards the in-flight operation; no response is ever produced for it.

Verification
REQ-030 req0 SLL data 0x00000001 shamt 31 -> resp_valid 2 cycles after accept, resp_data 0x80000000, resp_id 0.
REQ-031 req1 SRA data 0x80000000 shamt 4 -> 0xF8000000; same as SRL -> 0x08000000; SRA 0x80000001 shamt 0 -> 0x80000001.
REQ-032 After reset, req0 and req1 valid together and held -> grants req0, req1, req0, req1; resp_id sequence 0,1,0,1.
REQ-033 resp_ready held low 5 cycles in RESP -> resp_data/resp_id stable, both readies 0, busy 1; release -> IDLE next cycle.
REQ-034 rst_n pulsed low during SHIFT -> resp_valid 0 and busy 0 asynchronously, no response after release, next contention granted to req0.
REQ-035 req0_op 10 data 0x0000000F shamt 4 -> resp_data 0x000000F0.

Source files
------------

// File: rtl/shift_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared 32-bit left barrel shifter.
// SRL/SRA are built by bit-reversing the operand and result around the
// external left shifter; SRA adds a sign-fill mask. One operation in flight.
module shift_arbiter_ctrl #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id,
    output logic [31:0] sh_idata,
    output logic [4:0]  sh_shift_len,
    input  logic [31:0] sh_odata,
    output logic        busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        last_grant_r;
    logic        grant_s;
    logic        accept_s;
    logic [1:0]  sel_op_s;
    logic [1:0]  op_r;
    logic [31:0] data_r;
    logic [4:0]  shamt_r;
    logic        id_r;
    logic [31:0] res_r;
    logic        resp_id_r;
    logic [31:0] sign_mask_s;
    logic [31:0] shift_result_s;

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    // Round-robin grant and ready generation; only IDLE can accept.
    always_comb begin
        grant_s    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_s = ~last_grant_r;
            end else if (req1_valid) begin
                grant_s = 1'b1;
            end else begin
                grant_s = 1'b0;
            end
            req0_ready = req0_valid && (grant_s == 1'b0);
            req1_ready = req1_valid && (grant_s == 1'b1);
        end else begin
            grant_s    = 1'b0;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign accept_s = req0_ready | req1_ready;

    // Next-state logic for IDLE -> SHIFT -> RESP -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: state_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Remember the last winner so contention alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= RR_INIT;
        end else if (accept_s) begin
            last_grant_r <= grant_s;
        end
    end

    // Reserved opcode collapses to SLL so downstream logic sees three ops.
    always_comb begin
        sel_op_s = grant_s ? req1_op : req0_op;
        if (sel_op_s == OP_RSV) begin
            sel_op_s = OP_SLL;
        end else begin
            sel_op_s = sel_op_s;
        end
    end

    // Capture the winning request's operands on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= OP_SLL;
            data_r  <= 32'h0000_0000;
            shamt_r <= 5'd0;
            id_r    <= 1'b0;
        end else if (accept_s) begin
            op_r    <= sel_op_s;
            data_r  <= grant_s ? req1_data : req0_data;
            shamt_r <= grant_s ? req1_shamt : req0_shamt;
            id_r    <= grant_s;
        end
    end

    // Right shifts run through the left shifter on the reversed operand.
    assign sh_idata     = (op_r == OP_SLL) ? data_r : bit_rev(data_r);
    assign sh_shift_len = shamt_r;

    // Post-process the shifter output: un-reverse and sign-fill for SRA.
    always_comb begin
        if (data_r[31]) begin
            sign_mask_s = ~(32'hFFFF_FFFF >> shamt_r);
        end else begin
            sign_mask_s = 32'h0000_0000;
        end
        case (op_r)
            OP_SLL:  shift_result_s = sh_odata;
            OP_SRL:  shift_result_s = bit_rev(sh_odata);
            OP_SRA:  shift_result_s = bit_rev(sh_odata) | sign_mask_s;
            default: shift_result_s = sh_odata;
        endcase
    end

    // Result and owner are latched once in SHIFT and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r     <= 32'h0000_0000;
            resp_id_r <= 1'b0;
        end else if (state_r == SHIFT) begin
            res_r     <= shift_result_s;
            resp_id_r <= id_r;
        end
    end

    assign resp_data  = res_r;
    assign resp_id    = resp_id_r;
    assign resp_valid = (state_r == RESP);
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Directed bench for shift_arbiter_ctrl with a behavioural left shifter.
module tb_shift_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic [31:0] sh_idata;
    logic [4:0]  sh_shift_len;
    logic [31:0] sh_odata;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    // Shared shifter stand-in.
    assign sh_odata = sh_idata << sh_shift_len;

    shift_arbiter_ctrl #(.RR_INIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .sh_idata(sh_idata), .sh_shift_len(sh_shift_len),
        .sh_odata(sh_odata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] shamt);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_data = data; req1_shamt = shamt;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_data = data; req0_shamt = shamt;
        end
    endtask

    // Single uncontended operation with immediate response handshake.
    task automatic run_vec(input int k, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", k);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        drive(v.id, v.op, v.data, v.shamt);
        #1;
        chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_shift_busy"}, {30'd0, busy, resp_valid}, 32'd2);
        tick();
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_data"}, resp_data, v.exp);
        chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, v.id});
        tick();
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{1'b1, 2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2]  = '{1'b1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[3]  = '{1'b1, 2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001};
        vecs[4]  = '{1'b0, 2'b10, 32'h0000_000F, 5'd4,  32'h0000_00F0};
        vecs[5]  = '{1'b0, 2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F};
        vecs[6]  = '{1'b1, 2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[7]  = '{1'b0, 2'b11, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
        vecs[8]  = '{1'b1, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[9]  = '{1'b0, 2'b11, 32'h9000_0000, 5'd1,  32'hC800_0000};
        vecs[10] = '{1'b1, 2'b01, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD};
        vecs[11] = '{1'b0, 2'b00, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000};

        // Reset state with both requesters already valid.
        rst_n = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_data = 32'h0000_0001; req0_shamt = 5'd1;
        req1_valid = 1'b1; req1_op = 2'b00; req1_data = 32'h0000_0003; req1_shamt = 5'd2;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'h0000_0000);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_sh_idata", sh_idata, 32'h0000_0000);
        chk("rst_sh_len", {27'd0, sh_shift_len}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd1);

        // Held contention alternates 0,1,0,1.
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            int   waited;
            exp_id = k[0];
            waited = 0;
            while (!(req0_ready || req1_ready) && waited < 5) begin
                tick();
                waited++;
            end
            chk($sformatf("rr%0d_grant", k), {30'd0, req1_ready, req0_ready},
                exp_id ? 32'd2 : 32'd1);
            tick();
            tick();
            chk($sformatf("rr%0d_valid", k), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("rr%0d_id", k), {31'd0, resp_id}, {31'd0, exp_id});
            chk($sformatf("rr%0d_data", k), resp_data, exp_id ? 32'h0000_000C : 32'h0000_0002);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Directed vector table.
        for (int k = 0; k < 12; k++) begin
            run_vec(k, vecs[k]);
        end

        // Consumer back-pressure: RESP holds with no accepts.
        resp_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0000_00A5, 5'd8);
        tick();
        req0_valid = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_data", k), resp_data, 32'h0000_A500);
            chk($sformatf("hold%0d_id", k), {31'd0, resp_id}, 32'd0);
            chk($sformatf("hold%0d_ready", k), {30'd0, req1_ready, req0_ready}, 32'd0);
            chk($sformatf("hold%0d_busy_valid", k), {30'd0, busy, resp_valid}, 32'd3);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("hold_release_busy", {31'd0, busy}, 32'd0);
        chk("hold_release_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        req1_valid = 1'b0;
        tick();

        // Reset during SHIFT discards the operation; last grant was req0.
        drive(1'b0, 2'b00, 32'h0000_0001, 5'd3);
        tick();
        req0_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", k), {31'd0, resp_valid}, 32'd0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
